counter_rr_sched: RTL and testbench

- Round-robin scheduler that shares one synchronous binary interval counter between NREQ requesters.
- Each requester asks for a run of a given length in clock cycles. The block arbitrates, grants the counter to one requester, and sequences the run.
- It signals completion with a one-cycle done pulse, then releases the counter.
- Sits between requesting engines and the shared counter datapath. The counter is built inside this block.

---
 rtl/counter_rr_sched.sv | 108 ++++++++++
 tb/tb_counter_rr_sched.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/counter_rr_sched.sv
// rtl/counter_rr_sched.sv - round-robin scheduler sharing one interval counter between requesters
module counter_rr_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] len,
    input  logic                  abort,
    output logic [NREQ-1:0]       grant,
    output logic                  busy,
    output logic [WIDTH-1:0]      count,
    output logic [NREQ-1:0]       done
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    owner;
    logic [PW-1:0]    win;
    logic [PW-1:0]    next_ptr;
    logic [NREQ-1:0]  win_oh;
    logic [WIDTH-1:0] win_len;
    logic [WIDTH-1:0] cap_len;
    logic [WIDTH-1:0] last;
    logic             found;
    int               idx;

    // Winner search starts at ptr and wraps modulo NREQ; first requesting slot wins.
    always_comb begin
        win     = '0;
        found   = 1'b0;
        idx     = 0;
        win_oh  = '0;
        win_len = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (win == PW'(i)) begin
                win_oh[i] = found;
                win_len   = len[i*WIDTH +: WIDTH];
            end
        end
    end

    // A captured length of 0 wraps to all-ones here, giving the full 2^WIDTH run.
    assign last     = cap_len - WIDTH'(1);
    assign next_ptr = (owner == PW'(NREQ - 1)) ? '0 : owner + PW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            grant   <= '0;
            done    <= '0;
            busy    <= 1'b0;
            count   <= '0;
            ptr     <= '0;
            owner   <= '0;
            cap_len <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done  <= '0;
                    count <= '0;
                    if (found) begin
                        state   <= RUN;
                        grant   <= win_oh;
                        busy    <= 1'b1;
                        cap_len <= win_len;
                        owner   <= win;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                        grant <= '0;
                        busy  <= 1'b0;
                        count <= '0;
                        ptr   <= next_ptr;
                    end else if (count == last) begin
                        state <= DONE;
                        done  <= grant;
                    end else begin
                        count <= count + WIDTH'(1);
                    end
                end
                DONE: begin
                    // Abort here changes nothing: the visible done pulse stands either way.
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                    done  <= '0;
                    count <= '0;
                    ptr   <= next_ptr;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_counter_rr_sched.sv
// tb/tb_counter_rr_sched.sv - directed scoreboard bench for counter_rr_sched
module tb_counter_rr_sched;
    localparam int NREQ  = 4;
    localparam int WIDTH = 3;

    logic                  clk   = 1'b0;
    logic                  reset = 1'b1;
    logic [NREQ-1:0]       req   = '0;
    logic [NREQ*WIDTH-1:0] len   = '0;
    logic                  abort = 1'b0;
    logic [NREQ-1:0]       grant;
    logic                  busy;
    logic [WIDTH-1:0]      count;
    logic [NREQ-1:0]       done;

    typedef struct {
        int owner;
        int len;
    } exp_t;

    exp_t sb[$];
    int   checks  = 0;
    int   errors  = 0;
    int   mptr    = 0;
    int   cur_len = 0;

    counter_rr_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .len   (len),
        .abort (abort),
        .grant (grant),
        .busy  (busy),
        .count (count),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk("inv_onehot", 32'($onehot0(grant)), 1);
        chk("inv_done_subset", 32'((done & ~grant) == '0), 1);
        chk("inv_busy", 32'(busy), 32'(|grant));
    endtask

    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic int dec(input int v);
        return (v == 0) ? (1 << WIDTH) : v;
    endfunction

    task automatic set_len(input int i, input int v);
        len[i*WIDTH +: WIDTH] = WIDTH'(v);
    endtask

    task automatic push();
        exp_t e;
        e.owner = pick(req, mptr);
        e.len   = dec(int'(len[e.owner*WIDTH +: WIDTH]));
        sb.push_back(e);
    endtask

    task automatic wait_grant(output int n, output int owner);
        exp_t e;
        n = 0;
        do begin
            tick();
            n++;
        end while (grant == '0 && n < 20);
        chk("grant_seen", 32'(grant != '0), 1);
        chk("sb_nonempty", 32'(sb.size() != 0), 1);
        owner   = 0;
        cur_len = 1;
        if (sb.size() != 0) begin
            e       = sb.pop_front();
            owner   = e.owner;
            cur_len = e.len;
        end
        chk("grant_owner", 32'(grant), 32'(1 << owner));
    endtask

    task automatic check_run(input int owner, input int l);
        for (int c = 0; c < l; c++) begin
            chk("run_count", 32'(count), 32'(c));
            chk("run_grant", 32'(grant), 32'(1 << owner));
            chk("run_done", 32'(done), 0);
            tick();
        end
        chk("done_pulse", 32'(done), 32'(1 << owner));
        chk("done_count", 32'(count), 32'(l - 1));
        chk("done_grant", 32'(grant), 32'(1 << owner));
        tick();
        chk("idle_grant", 32'(grant), 0);
        chk("idle_count", 32'(count), 0);
        chk("idle_done", 32'(done), 0);
        mptr = (owner + 1) % NREQ;
    endtask

    initial begin
        int n;
        int o;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_grant", 32'(grant), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_count", 32'(count), 0);
        chk("reset_done", 32'(done), 0);
        reset = 1'b0;

        // Round robin with every requester holding req and len=1
        req = 4'b1111;
        for (int i = 0; i < NREQ; i++) set_len(i, 1);
        for (int i = 0; i < 5; i++) begin
            push();
            wait_grant(n, o);
            chk("rr_idle_gap", 32'(n), 1);
            chk("rr_order", 32'(o), 32'(i % NREQ));
            check_run(o, cur_len);
        end
        req = '0;

        // Single request, len=3
        req = 4'b0001;
        set_len(0, 3);
        push();
        wait_grant(n, o);
        req = '0;
        check_run(o, cur_len);

        // Wrap length, len=0 means 8 cycles
        req = 4'b0001;
        set_len(0, 0);
        push();
        wait_grant(n, o);
        req = '0;
        chk("wrap_len", 32'(cur_len), 8);
        check_run(o, cur_len);

        // Abort at count=2, then requester 2 takes over
        req = 4'b0110;
        set_len(1, 5);
        set_len(2, 2);
        push();
        wait_grant(n, o);
        chk("abort_owner", 32'(o), 1);
        for (int c = 0; c < 3; c++) begin
            chk("abort_count", 32'(count), 32'(c));
            chk("abort_no_done", 32'(done), 0);
            if (c == 2) abort = 1'b1;
            tick();
        end
        chk("abort_grant", 32'(grant), 0);
        chk("abort_cnt0", 32'(count), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        abort = 1'b0;
        mptr  = (o + 1) % NREQ;
        push();
        wait_grant(n, o);
        req = '0;
        chk("after_abort_owner", 32'(o), 2);
        check_run(o, cur_len);

        // Asynchronous reset in mid-run
        req = 4'b0100;
        set_len(2, 6);
        push();
        wait_grant(n, o);
        for (int c = 0; c < 4; c++) begin
            chk("prereset_count", 32'(count), 32'(c));
            if (c < 3) tick();
        end
        reset = 1'b1;
        #1;
        chk("areset_grant", 32'(grant), 0);
        chk("areset_count", 32'(count), 0);
        chk("areset_busy", 32'(busy), 0);
        req = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        mptr  = 0;
        req   = 4'b0101;
        set_len(0, 2);
        push();
        wait_grant(n, o);
        req = '0;
        chk("post_reset_owner", 32'(o), 0);
        check_run(o, cur_len);

        // len and req changes after capture are ignored
        req = 4'b0001;
        set_len(0, 4);
        push();
        wait_grant(n, o);
        req = '0;
        set_len(0, 1);
        check_run(o, cur_len);

        // abort while idle neither blocks nor cancels a grant
        req   = 4'b0010;
        set_len(1, 1);
        abort = 1'b1;
        push();
        wait_grant(n, o);
        abort = 1'b0;
        req   = '0;
        check_run(o, cur_len);

        repeat (3) tick();
        chk("final_idle_grant", 32'(grant), 0);
        chk("final_sb_empty", 32'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
